// File: rtl/corr_window_ctrl.sv
// Correlation window controller: flushes and primes the correlator, integrates
// pos/neg votes and the corr peak over win_len sample strobes, then holds the result.
module corr_window_ctrl #(
   parameter int WIN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [7:0]       clk_div,
   input  logic [7:0]       length_cfg,
   input  logic [WIN_W-1:0] win_len,
   input  logic [7:0]       corr,
   input  logic             pos,
   input  logic             neg,
   output logic             sample_en,
   output logic             buf_rst,
   output logic [7:0]       buf_length,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [1:0]       dir,
   output logic [WIN_W-1:0] pos_cnt,
   output logic [WIN_W-1:0] neg_cnt,
   output logic [7:0]       corr_peak
);

   localparam int CW = (WIN_W > 8) ? WIN_W : 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_FILL,
      S_ACQ,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [7:0]       r_div_cfg;
   logic [7:0]       r_div_cnt;
   logic [7:0]       r_buf_length;
   logic             r_buf_rst;
   logic [WIN_W-1:0] r_win_len;
   logic [WIN_W-1:0] r_pos_cnt;
   logic [WIN_W-1:0] r_neg_cnt;
   logic [7:0]       r_corr_peak;
   logic [CW-1:0]    r_samp_cnt;

   logic             w_run;
   logic             w_strobe;
   logic             w_launch;
   logic             w_fill_last;
   logic             w_acq_last;
   logic [CW-1:0]    w_samp_inc;

   always_comb begin
      w_run       = (r_state == S_FILL) || (r_state == S_ACQ);
      w_strobe    = w_run && (r_div_cnt == r_div_cfg) && !abort;
      w_launch    = (r_state == S_IDLE) && start && !abort;
      w_samp_inc  = r_samp_cnt + CW'(1);
      w_fill_last = (r_state == S_FILL) && w_strobe && (w_samp_inc == CW'(r_buf_length));
      w_acq_last  = (r_state == S_ACQ)  && w_strobe && (w_samp_inc == CW'(r_win_len));
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start)        w_next = S_FLUSH;
         S_FLUSH:                   w_next = S_FILL;
         S_FILL:  if (w_fill_last)  w_next = S_ACQ;
         S_ACQ:   if (w_acq_last)   w_next = S_DONE;
         S_DONE:  if (result_ready) w_next = S_IDLE;
         default:                   w_next = S_IDLE;
      endcase
      // abort overrides every transition, including the IDLE->FLUSH launch
      if (abort) w_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_buf_rst    <= 1'b1;
         r_buf_length <= '0;
         r_div_cfg    <= '0;
         r_div_cnt    <= '0;
         r_win_len    <= '0;
         r_samp_cnt   <= '0;
         r_pos_cnt    <= '0;
         r_neg_cnt    <= '0;
         r_corr_peak  <= '0;
      end else begin
         r_state   <= w_next;
         r_buf_rst <= (w_next == S_FLUSH);

         if (w_launch) begin
            r_div_cfg    <= clk_div;
            r_buf_length <= (length_cfg == '0) ? 8'd1 : length_cfg;
            r_win_len    <= (win_len == '0) ? WIN_W'(1) : win_len;
            r_pos_cnt    <= '0;
            r_neg_cnt    <= '0;
            r_corr_peak  <= '0;
         end

         if (w_run && !abort)
            r_div_cnt <= (r_div_cnt == r_div_cfg) ? 8'd0 : r_div_cnt + 8'd1;
         else
            r_div_cnt <= '0;

         // one counter serves both phases: it restarts when FILL hands over to ACQ
         if (!w_run)
            r_samp_cnt <= '0;
         else if (w_strobe)
            r_samp_cnt <= (w_fill_last || w_acq_last) ? '0 : w_samp_inc;

         if ((r_state == S_ACQ) && w_strobe) begin
            if (pos && (r_pos_cnt != '1)) r_pos_cnt <= r_pos_cnt + WIN_W'(1);
            if (neg && (r_neg_cnt != '1)) r_neg_cnt <= r_neg_cnt + WIN_W'(1);
            if (corr > r_corr_peak)       r_corr_peak <= corr;
         end
      end
   end

   always_comb begin
      sample_en    = w_strobe;
      busy         = (r_state != S_IDLE);
      result_valid = (r_state == S_DONE) && !abort;
      dir          = 2'b00;
      if (r_state == S_DONE) begin
         if (r_pos_cnt > r_neg_cnt)      dir = 2'b01;
         else if (r_neg_cnt > r_pos_cnt) dir = 2'b10;
      end
   end

   assign buf_rst    = r_buf_rst;
   assign buf_length = r_buf_length;
   assign pos_cnt    = r_pos_cnt;
   assign neg_cnt    = r_neg_cnt;
   assign corr_peak  = r_corr_peak;

endmodule
